// File: rtl/overlay_loader_if.sv
// Overlay loader bus bundle: hps_io byte stream in, SDRAM write handshake out.
// master = loader view, slave = host/SDRAM view.
interface overlay_loader_if #(
   parameter int AW = 24
);
   logic          ioctl_wr;
   logic [AW:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic          ioctl_wait;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_din;
   logic          mem_req;
   logic          mem_ack;

   modport master (
      input  ioctl_wr,
      input  ioctl_addr,
      input  ioctl_dout,
      output ioctl_wait,
      output mem_addr,
      output mem_din,
      output mem_req,
      input  mem_ack
   );

   modport slave (
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout,
      input  ioctl_wait,
      input  mem_addr,
      input  mem_din,
      input  mem_req,
      output mem_ack
   );
endinterface

// File: rtl/overlay_loader.sv
// Overlay writer: packs download bytes into RGBA4444 words and
// pushes them through a small FIFO to a req/ack SDRAM write port.
module overlay_loader #(
   parameter int FIFO_DEPTH = 4,
   parameter int AW         = 24
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             dl_active,
   overlay_loader_if.master bus,
   output logic             ovl_valid,
   output logic [AW-1:0]    ovl_words
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int EW = AW + 16;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] HIGH = CW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DRAIN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic          dl_prev;
   logic          rise;
   logic          fall;
   logic          byte_in;
   logic          ack_ok;
   logic          restart;
   logic          finish;
   logic          push;
   logic          push_ok;
   logic          pop;
   logic [EW-1:0] push_entry;

   logic          pend;
   logic [7:0]    lo_byte;
   logic [AW-1:0] even_addr;
   logic          stale;
   logic          req;
   logic          wait_q;
   logic [AW-1:0] addr_q;
   logic [15:0]   din_q;

   logic [EW-1:0] fifo [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   assign rise    = dl_active & ~dl_prev;
   assign fall    = ~dl_active & dl_prev;
   assign byte_in = (state == LOAD) & dl_active & bus.ioctl_wr;
   assign ack_ok  = req & bus.mem_ack;

   assign bus.ioctl_wait = wait_q;
   assign bus.mem_req    = req;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_din    = din_q;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      restart    = 1'b0;
      finish     = 1'b0;
      push       = 1'b0;
      push_entry = '0;
      unique case (state)
         IDLE, DONE: begin
            if (rise) begin
               state_nx = LOAD;
               restart  = 1'b1;
            end
         end
         LOAD: begin
            if (byte_in && bus.ioctl_addr[0]) begin
               push       = 1'b1;
               push_entry = {bus.ioctl_addr[AW:1],
                             bus.ioctl_dout, lo_byte};
            end
            // a trailing even byte is padded with a zero high byte
            if (fall) begin
               state_nx = DRAIN;
               if (pend) begin
                  push       = 1'b1;
                  push_entry = {even_addr, 8'h00, lo_byte};
               end
            end
         end
         DRAIN: begin
            if (rise) begin
               state_nx = LOAD;
               restart  = 1'b1;
            end else if (count == '0 && !req) begin
               state_nx = DONE;
               finish   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign pop     = !req && (count != '0) && !restart;
   assign push_ok = push && !restart && ((count != FULL) || pop);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         dl_prev   <= 1'b0;
         pend      <= 1'b0;
         lo_byte   <= 8'h00;
         even_addr <= '0;
      end else begin
         dl_prev <= dl_active;
         if (restart) begin
            pend <= 1'b0;
         end else if (fall && state == LOAD) begin
            pend <= 1'b0;
         end else if (byte_in) begin
            if (bus.ioctl_addr[0]) begin
               pend <= 1'b0;
            end else begin
               pend      <= 1'b1;
               lo_byte   <= bus.ioctl_dout;
               even_addr <= bus.ioctl_addr[AW:1];
            end
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok) fifo[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (restart) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (pop && !push_ok) count <= count - 1'b1;
      end
   end

   // a request in flight at restart completes but is not counted
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         req    <= 1'b0;
         addr_q <= '0;
         din_q  <= 16'h0000;
         stale  <= 1'b0;
      end else begin
         if (pop) begin
            req             <= 1'b1;
            {addr_q, din_q} <= fifo[rd_ptr];
         end else if (ack_ok) begin
            req <= 1'b0;
         end
         if (restart)     stale <= req & ~bus.mem_ack;
         else if (ack_ok) stale <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wait_q    <= 1'b0;
         ovl_words <= '0;
         ovl_valid <= 1'b0;
      end else begin
         wait_q <= (state_nx == LOAD) && (count >= HIGH);
         if (restart) begin
            ovl_words <= '0;
            ovl_valid <= 1'b0;
         end else begin
            if (ack_ok && !stale) ovl_words <= ovl_words + 1'b1;
            if (finish)           ovl_valid <= (ovl_words != '0);
         end
      end
   end

endmodule
